iomem_arbiter: RTL and testbench

Two-master, one-slave arbiter for the PicoSoC `iomem` bus. It lets the CPU's iomem port and a second bus master share the board peripheral register file (GPIO, LED and MMIO registers) through a single iomem slave port. It arbitrates round-robin and holds the grant until the slave completes. An optional watchdog ends transactions that the slave never acknowledges.

---
 rtl/iomem_arbiter.sv | 97 +++++++++
 tb/tb_iomem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: two-master round-robin arbiter for the PicoSoC iomem bus.
// Define IOMEM_ARB_TIMEOUT_EN to enable the watchdog that ends unacknowledged transactions.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        err_clr
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic last_q, last_d;
  logic busy, sel1, req, tmo, done;
  assign busy = state_q == BUSY;
  assign sel1 = grant_q[1];
  assign req = busy & (sel1 ? m1_valid : m0_valid);
  // Reset low aborts the transaction: no master sees a ready in that cycle.
  assign done = resetn & req & (s_ready | tmo);
  assign s_valid = req;
  assign s_wstrb = busy ? (sel1 ? m1_wstrb : m0_wstrb) : '0;
  assign s_addr = busy ? (sel1 ? m1_addr : m0_addr) : '0;
  assign s_wdata = busy ? (sel1 ? m1_wdata : m0_wdata) : '0;
  assign m0_ready = done & grant_q[0];
  assign m1_ready = done & grant_q[1];
  assign m0_rdata = m0_ready ? (tmo ? ERR_RDATA : s_rdata) : '0;
  assign m1_rdata = m1_ready ? (tmo ? ERR_RDATA : s_rdata) : '0;
  assign grant = grant_q;
`ifdef IOMEM_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;
  logic terr_q, terr_d;
  assign tmo = req & ~s_ready & (tcnt_q == 16'(TIMEOUT_CYCLES - 1));
  // Held at zero while idle so every transaction starts counting from 0.
  assign tcnt_d = busy ? (s_ready ? tcnt_q : tcnt_q + 16'd1) : '0;
  assign terr_d = tmo | (terr_q & ~err_clr);
  always_ff @(posedge clk)
    if (!resetn) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      terr_q <= terr_d;
    end
  assign timeout_err = terr_q;
`else
  logic unused_cfg;
  assign unused_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    if (!busy) begin
      if (m0_valid | m1_valid) begin
        state_d = BUSY;
        grant_d = (m0_valid & m1_valid) ? (last_q ? 2'b01 : 2'b10) : {m1_valid, m0_valid};
      end
    end else if (!req | done) begin
      state_d = IDLE;
      grant_d = '0;
      last_d = done ? sel1 : last_q;
    end
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter: directed vector table, timeout sequences and a randomized run
// against a transaction-level model of the arbiter.
module tb_iomem_arbiter;
  localparam int TC = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [31:0] A0 = 32'h0300_0000, W0 = 32'h0000_00A5;
  localparam logic [31:0] A1 = 32'h0400_0000, W1 = 32'h1111_2222;
`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  logic m0_valid = 1'b0, m1_valid = 1'b0, m0_ready, m1_ready;
  logic [3:0] m0_wstrb = '0, m1_wstrb = '0, s_wstrb;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata;
  logic s_valid, s_ready = 1'b0;
  logic [31:0] s_addr, s_wdata, s_rdata = '0;
  logic [1:0] grant;
  logic timeout_err, err_clr = 1'b0;
  int checks = 0, failures = 0;

  iomem_arbiter #(.TIMEOUT_CYCLES(TC), .ERR_RDATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rn, v0, v1, sr;
    logic [31:0] rd;
    logic [1:0] g;
    logic sv, r0, r1;
    logic [31:0] d0, d1;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rn, v0, v1, sr, input logic [31:0] rd, input logic [1:0] g,
                     input logic sv, r0, r1, input logic [31:0] d0, d1);
    vec_t v;
    v.rn = rn; v.v0 = v0; v.v1 = v1; v.sr = sr; v.rd = rd;
    v.g = g; v.sv = sv; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 50) $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rn, v0, v1, sr, input logic [31:0] rd, input logic clr);
    resetn = rn; m0_valid = v0; m1_valid = v1; s_ready = sr; s_rdata = rd; err_clr = clr;
    #2;
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: who owns the slave, who was served last, and how long it has waited.
  int owner = 0, last = 2, age = 0;
  bit err = 1'b0;

  initial begin
    logic q, tmo, fin, e0, e1, g0, g1;
    logic [31:0] ed;
    add(0,0,0,0,0,        0,0,0,0,0,0);
    add(1,1,0,0,0,        0,0,0,0,0,0);
    add(1,1,0,0,0,        1,1,0,0,0,0);
    add(1,1,0,1,'h1234,   1,1,1,0,'h1234,0);
    add(1,0,0,0,0,        0,0,0,0,0,0);
    add(0,1,1,0,0,        0,0,0,0,0,0);
    add(1,1,1,0,0,        0,0,0,0,0,0);
    add(1,1,1,1,'h77,     1,1,1,0,'h77,0);
    add(1,1,1,0,0,        0,0,0,0,0,0);
    add(1,1,1,1,5,        2,1,0,1,0,5);
    add(1,1,1,0,0,        0,0,0,0,0,0);
    add(1,1,1,0,0,        1,1,0,0,0,0);
    add(1,1,1,1,9,        1,1,1,0,9,0);
    add(1,1,1,0,0,        0,0,0,0,0,0);
    add(1,1,1,1,5,        2,1,0,1,0,5);
    add(1,1,1,0,0,        0,0,0,0,0,0);
    add(0,1,1,1,'h66,     1,1,0,0,0,0);
    add(1,1,1,1,'h66,     0,0,0,0,0,0);
    add(1,1,1,0,0,        1,1,0,0,0,0);
    add(1,1,1,1,'h11,     1,1,1,0,'h11,0);
    add(1,1,1,0,0,        0,0,0,0,0,0);
    add(1,1,0,1,'h99,     2,0,0,0,0,0);
    add(1,1,1,0,0,        0,0,0,0,0,0);
    add(1,1,1,1,5,        2,1,0,1,0,5);
    add(1,0,0,0,0,        0,0,0,0,0,0);
    m0_addr = A0; m0_wdata = W0; m0_wstrb = 4'hF;
    m1_addr = A1; m1_wdata = W1; m1_wstrb = 4'h0;
    adv;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rn, tbl[i].v0, tbl[i].v1, tbl[i].sr, tbl[i].rd, 1'b0);
      chk($sformatf("row%0d grant", i), grant, tbl[i].g);
      chk($sformatf("row%0d s_valid", i), s_valid, tbl[i].sv);
      chk($sformatf("row%0d s_addr", i), s_addr, tbl[i].g == 2'b01 ? A0 : tbl[i].g == 2'b10 ? A1 : 0);
      chk($sformatf("row%0d s_wdata", i), s_wdata, tbl[i].g == 2'b01 ? W0 : tbl[i].g == 2'b10 ? W1 : 0);
      chk($sformatf("row%0d s_wstrb", i), s_wstrb, tbl[i].g == 2'b01 ? 32'hF : 0);
      chk($sformatf("row%0d m0_ready", i), m0_ready, tbl[i].r0);
      chk($sformatf("row%0d m1_ready", i), m1_ready, tbl[i].r1);
      chk($sformatf("row%0d m0_rdata", i), m0_rdata, tbl[i].d0);
      chk($sformatf("row%0d m1_rdata", i), m1_rdata, tbl[i].d1);
      chk($sformatf("row%0d timeout_err", i), timeout_err, 0);
      adv;
    end
    if (TMO_EN) begin
      drive(1,1,0,0,0,0); chk("to idle grant", grant, 0); adv;
      repeat (TC - 1) begin drive(1,1,0,0,0,0); chk("to wait m0_ready", m0_ready, 0); adv; end
      drive(1,1,0,0,0,0);
      chk("to m0_ready", m0_ready, 1); chk("to m0_rdata", m0_rdata, ERR); chk("to err not yet", timeout_err, 0);
      adv;
      drive(1,0,0,0,0,0); chk("to err set", timeout_err, 1); chk("to grant cleared", grant, 0); adv;
      drive(1,0,0,0,0,0); chk("to err sticky", timeout_err, 1); adv;
      drive(1,0,0,0,0,1); adv;
      drive(1,0,0,0,0,0); chk("to err cleared", timeout_err, 0);
      drive(1,1,0,0,0,0); adv;
      repeat (TC - 1) begin drive(1,1,0,0,0,0); adv; end
      drive(1,1,0,1,'h42,0); chk("rdy@to m0_ready", m0_ready, 1); chk("rdy@to m0_rdata", m0_rdata, 'h42); adv;
      drive(1,0,0,0,0,0); chk("rdy@to no err", timeout_err, 0); chk("rdy@to grant", grant, 0); adv;
      drive(1,1,0,0,0,0); adv;
      repeat (TC - 1) begin drive(1,1,0,0,0,0); adv; end
      drive(1,1,0,0,0,1); chk("set+clr m0_ready", m0_ready, 1); adv;
      drive(1,0,0,0,0,0); chk("set+clr err wins", timeout_err, 1); adv;
      drive(1,0,0,0,0,1); adv;
    end else begin
      drive(1,1,0,0,0,0); adv;
      repeat (10) begin
        drive(1,1,0,0,0,1);
        chk("wait grant", grant, 1); chk("wait m0_ready", m0_ready, 0); chk("wait err", timeout_err, 0);
        adv;
      end
      drive(1,1,0,1,'h5,0); chk("late m0_ready", m0_ready, 1); chk("late m0_rdata", m0_rdata, 5); adv;
      drive(1,0,0,0,0,0); adv;
    end
    drive(0,0,0,0,0,0); adv;
    owner = 0; last = 2; age = 0; err = 1'b0; g0 = 1'b0; g1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      resetn = $urandom_range(0, 199) != 0;
      if (!m0_valid || g0 || $urandom_range(0, 39) == 0) begin
        m0_valid = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      end
      if (!m1_valid || g1 || $urandom_range(0, 39) == 0) begin
        m1_valid = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      end
      s_ready = $urandom_range(0, 2) == 0;
      s_rdata = $urandom;
      err_clr = $urandom_range(0, 7) == 0;
      #1;
      q = owner == 1 ? m0_valid : owner == 2 ? m1_valid : 1'b0;
      tmo = TMO_EN && resetn && q && !s_ready && age + 1 == TC;
      fin = resetn && q && (s_ready || tmo);
      e0 = fin && owner == 1;
      e1 = fin && owner == 2;
      ed = tmo ? ERR : s_rdata;
      chk("rnd grant", grant, owner == 1 ? 1 : owner == 2 ? 2 : 0);
      chk("rnd s_valid", s_valid, q);
      chk("rnd s_addr", s_addr, owner == 1 ? m0_addr : owner == 2 ? m1_addr : 0);
      chk("rnd s_wdata", s_wdata, owner == 1 ? m0_wdata : owner == 2 ? m1_wdata : 0);
      chk("rnd s_wstrb", s_wstrb, owner == 1 ? 32'(m0_wstrb) : owner == 2 ? 32'(m1_wstrb) : 0);
      chk("rnd m0_ready", m0_ready, e0);
      chk("rnd m1_ready", m1_ready, e1);
      chk("rnd m0_rdata", m0_rdata, e0 ? ed : 0);
      chk("rnd m1_rdata", m1_rdata, e1 ? ed : 0);
      chk("rnd timeout_err", timeout_err, err);
      g0 = e0;
      g1 = e1;
      if (!resetn) begin
        owner = 0; last = 2; age = 0; err = 1'b0;
      end else begin
        if (tmo) err = 1'b1;
        else if (err_clr) err = 1'b0;
        if (owner == 0) begin
          if (m0_valid && m1_valid) owner = last == 1 ? 2 : 1;
          else if (m0_valid) owner = 1;
          else if (m1_valid) owner = 2;
          age = 0;
        end else if (!q) owner = 0;
        else if (fin) begin
          last = owner;
          owner = 0;
        end else age++;
      end
      adv;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
